// File: rtl/tinyrisc_pkg.sv
// Shared TinyRISC types for the ID->EX boundary: payload layout, bubble constant, defaults.
package tinyrisc_pkg;

  localparam int unsigned TR_XLEN   = 32;
  localparam int unsigned TR_CTRL_W = 22;
  localparam logic [TR_XLEN-1:0] TR_NOP_INSTR = 32'h6800_0000;

  typedef struct packed {
    logic                 valid;
    logic [TR_XLEN-1:0]   pc;
    logic [TR_XLEN-1:0]   instr;
    logic [TR_XLEN-1:0]   a;
    logic [TR_XLEN-1:0]   b;
    logic [TR_XLEN-1:0]   op2;
    logic [TR_CTRL_W-1:0] ctrl;
    logic [TR_XLEN-1:0]   bt;
  } idex_payload_t;

  localparam idex_payload_t IDEX_BUBBLE = '{
    valid: 1'b0,
    pc:    '0,
    instr: TR_NOP_INSTR,
    a:     '0,
    b:     '0,
    op2:   '0,
    ctrl:  '0,
    bt:    '0
  };

endpackage

// File: rtl/idex_slot.sv
// One ID->EX payload register: clear (reset or squash) beats load, load beats hold.
module idex_slot
  import tinyrisc_pkg::*;
#(
  parameter logic [TR_XLEN-1:0] NopInstr = TR_NOP_INSTR
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          clear_i,
  input  idex_payload_t d_i,
  output idex_payload_t q_o
);

  idex_payload_t bubble;
  idex_payload_t slot_d, slot_q;

  always_comb begin
    bubble       = IDEX_BUBBLE;
    bubble.instr = NopInstr;
  end

  always_comb begin
    slot_d = slot_q;
    if (clear_i) begin
      slot_d = bubble;
    end else if (load_i) begin
      slot_d = d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q <= bubble;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign q_o = slot_q;

endmodule

// File: rtl/idex_stage_reg.sv
// ID->EX pipeline register: DEPTH valid-tagged slots with stall/flush/bubble handling and
// saturating stall/bubble counters.
module idex_stage_reg
  import tinyrisc_pkg::*;
#(
  parameter int unsigned        XLEN      = TR_XLEN,
  parameter int unsigned        CTRL_W    = TR_CTRL_W,
  parameter int unsigned        DEPTH     = 1,
  parameter int unsigned        CNT_W     = 16,
  parameter logic [XLEN-1:0]    NOP_INSTR = TR_NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   instruction,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic [XLEN-1:0]   op2,
  input  logic [XLEN-1:0]   branch_target,
  input  logic [CTRL_W-1:0] control,
  output logic              out_valid,
  output logic [XLEN-1:0]   pcc,
  output logic [XLEN-1:0]   instr,
  output logic [XLEN-1:0]   ao,
  output logic [XLEN-1:0]   bo,
  output logic [XLEN-1:0]   oppo,
  output logic [XLEN-1:0]   bto,
  output logic [CTRL_W-1:0] co,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // The payload struct has fixed field widths, so XLEN/CTRL_W must match the package.
  if (DEPTH < 1 || DEPTH > 4) begin : gen_bad_depth
    $error("idex_stage_reg: DEPTH must be in 1..4");
  end
  if (CNT_W < 2) begin : gen_bad_cnt_w
    $error("idex_stage_reg: CNT_W must be at least 2");
  end
  if (XLEN != TR_XLEN || CTRL_W != TR_CTRL_W) begin : gen_bad_width
    $error("idex_stage_reg: XLEN/CTRL_W must match tinyrisc_pkg");
  end

  localparam logic [CNT_W-1:0] CntMax = '1;

  idex_payload_t in_payload;
  idex_payload_t slot_q [DEPTH];

  always_comb begin
    in_payload       = IDEX_BUBBLE;
    in_payload.instr = NOP_INSTR;
    if (in_valid) begin
      in_payload.valid = 1'b1;
      in_payload.pc    = pc;
      in_payload.instr = instruction;
      in_payload.a     = a;
      in_payload.b     = b;
      in_payload.op2   = op2;
      in_payload.ctrl  = control;
      in_payload.bt    = branch_target;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : gen_slot
    idex_payload_t slot_d;
    if (k == 0) begin : gen_head
      assign slot_d = in_payload;
    end else begin : gen_tail
      assign slot_d = slot_q[k-1];
    end
    idex_slot #(
      .NopInstr (NOP_INSTR)
    ) u_slot (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (!stall),
      .clear_i (flush),
      .d_i     (slot_d),
      .q_o     (slot_q[k])
    );
  end

  assign out_valid = slot_q[DEPTH-1].valid;
  assign pcc       = slot_q[DEPTH-1].pc;
  assign instr     = slot_q[DEPTH-1].instr;
  assign ao        = slot_q[DEPTH-1].a;
  assign bo        = slot_q[DEPTH-1].b;
  assign oppo      = slot_q[DEPTH-1].op2;
  assign bto       = slot_q[DEPTH-1].bt;
  assign co        = slot_q[DEPTH-1].ctrl;

  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
  logic             stall_inc, bubble_inc;

  // A flush squashes the stall, and counts as a single bubble regardless of depth.
  assign stall_inc  = stall && !flush;
  assign bubble_inc = flush || (!stall && !in_valid);

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (stall_inc && stall_cnt_q != CntMax) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (bubble_inc && bubble_cnt_q != CntMax) begin
        bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_idex_stage_reg.sv
// Bench for idex_stage_reg: a DEPTH=2 instance and a DEPTH=1/CNT_W=2 instance driven in lockstep.
module tb_idex_stage_reg;
  import tinyrisc_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush, cnt_clr;
  logic [31:0] pc, instruction, a, b, op2, branch_target;
  logic [21:0] control;

  logic        ov2, ov1;
  logic [31:0] pcc2, instr2, ao2, bo2, oppo2, bto2;
  logic [31:0] pcc1, instr1, ao1, bo1, oppo1, bto1;
  logic [21:0] co2, co1;
  logic [15:0] sc2, bc2;
  logic [1:0]  sc1, bc1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  idex_stage_reg #(.DEPTH(2), .CNT_W(16)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .pc(pc), .instruction(instruction), .a(a), .b(b), .op2(op2),
    .branch_target(branch_target), .control(control),
    .out_valid(ov2), .pcc(pcc2), .instr(instr2), .ao(ao2), .bo(bo2), .oppo(oppo2), .bto(bto2),
    .co(co2), .stall_cnt(sc2), .bubble_cnt(bc2)
  );

  idex_stage_reg #(.DEPTH(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .pc(pc), .instruction(instruction), .a(a), .b(b), .op2(op2),
    .branch_target(branch_target), .control(control),
    .out_valid(ov1), .pcc(pcc1), .instr(instr1), .ao(ao1), .bo(bo1), .oppo(oppo1), .bto(bto1),
    .co(co1), .stall_cnt(sc1), .bubble_cnt(bc1)
  );

  // Every payload field is derived from pc so one number identifies a whole instruction.
  function automatic idex_payload_t exp_payload(logic v, logic [31:0] p);
    idex_payload_t e;
    e.valid = v;
    e.pc    = v ? p : 32'h0;
    e.instr = v ? (p ^ 32'hA5A5_0000) : 32'h6800_0000;
    e.a     = v ? p + 32'd1 : 32'h0;
    e.b     = v ? p + 32'd2 : 32'h0;
    e.op2   = v ? p + 32'd3 : 32'h0;
    e.ctrl  = v ? (p[21:0] ^ 22'h155) : 22'h0;
    e.bt    = v ? p + 32'd4 : 32'h0;
    return e;
  endfunction

  function automatic idex_payload_t act2();
    return '{valid: ov2, pc: pcc2, instr: instr2, a: ao2, b: bo2, op2: oppo2, ctrl: co2, bt: bto2};
  endfunction

  function automatic idex_payload_t act1();
    return '{valid: ov1, pc: pcc1, instr: instr1, a: ao1, b: bo1, op2: oppo1, ctrl: co1, bt: bto1};
  endfunction

  task automatic drive(logic r, logic iv, logic st, logic fl, logic clr, logic [31:0] p);
    rst           = r;
    in_valid      = iv;
    stall         = st;
    flush         = fl;
    cnt_clr       = clr;
    pc            = p;
    instruction   = p ^ 32'hA5A5_0000;
    a             = p + 32'd1;
    b             = p + 32'd2;
    op2           = p + 32'd3;
    branch_target = p + 32'd4;
    control       = p[21:0] ^ 22'h155;
  endtask

  task automatic check(string name, int row, idex_payload_t act, idex_payload_t exp,
                       logic [15:0] asc, logic [15:0] esc, logic [15:0] abc, logic [15:0] ebc);
    n_checks++;
    if (act !== exp || asc !== esc || abc !== ebc) begin
      n_errors++;
      $display("FAIL %s row %0d: got %h sc=%0d bc=%0d, want %h sc=%0d bc=%0d",
               name, row, act, asc, abc, exp, esc, ebc);
    end
  endtask

  task automatic check_pl(string name, int idx, idex_payload_t act, idex_payload_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s #%0d: got %h, want %h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        r, iv, st, fl, clr;
    logic [31:0] p;
    logic        v2;
    logic [31:0] p2;
    logic [15:0] s2, b2;
    logic        v1;
    logic [31:0] p1;
    logic [15:0] s1, b1;
  } vec_t;

  function automatic vec_t mk(logic r, logic iv, logic st, logic fl, logic clr, logic [31:0] p,
                              logic v2, logic [31:0] p2, int s2, int b2,
                              logic v1, logic [31:0] p1, int s1, int b1);
    vec_t t;
    t.r = r; t.iv = iv; t.st = st; t.fl = fl; t.clr = clr; t.p = p;
    t.v2 = v2; t.p2 = p2; t.s2 = 16'(s2); t.b2 = 16'(b2);
    t.v1 = v1; t.p1 = p1; t.s1 = 16'(s1); t.b1 = 16'(b1);
    return t;
  endfunction

  vec_t        tbl[$];
  vec_t        exp_q[$];
  logic [31:0] sb2[$];
  logic [31:0] sb1[$];

  initial begin
    vec_t        e;
    logic [31:0] np;
    logic        r_iv, r_st, r_fl;
    int          n_pop2, n_pop1;

    //        rst iv st fl clr pc      | D2: v pc sc bc      | D1: v pc sc bc
    tbl.push_back(mk(1, 0, 0, 0, 0, 'h000,  0, 'h000, 0, 0,  0, 'h000, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 'h000,  0, 'h000, 0, 0,  0, 'h000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 'h100,  0, 'h000, 0, 0,  1, 'h100, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 'h104,  1, 'h100, 0, 0,  1, 'h104, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 'h108,  1, 'h104, 0, 0,  1, 'h108, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 'h000,  1, 'h108, 0, 1,  0, 'h000, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 'h010,  0, 'h000, 0, 1,  1, 'h010, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 'h014,  1, 'h010, 0, 1,  1, 'h014, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 'h018,  1, 'h010, 1, 1,  1, 'h014, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 'h018,  1, 'h010, 2, 1,  1, 'h014, 2, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 'h018,  1, 'h010, 3, 1,  1, 'h014, 3, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 'h018,  1, 'h014, 0, 0,  1, 'h018, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 'h01c,  0, 'h000, 0, 1,  0, 'h000, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 'h01c,  0, 'h000, 1, 1,  0, 'h000, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 'h020,  0, 'h000, 1, 1,  1, 'h020, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 'h024,  1, 'h020, 1, 1,  1, 'h024, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 'h000,  1, 'h024, 1, 2,  0, 'h000, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 'h000,  0, 'h000, 1, 3,  0, 'h000, 1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 'h000,  0, 'h000, 1, 4,  0, 'h000, 1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 'h000,  0, 'h000, 1, 5,  0, 'h000, 1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 'h000,  0, 'h000, 1, 6,  0, 'h000, 1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 'h000,  0, 'h000, 1, 7,  0, 'h000, 1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h000,  0, 'h000, 0, 0,  0, 'h000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 'h030,  0, 'h000, 0, 0,  1, 'h030, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 'h034,  1, 'h030, 0, 0,  1, 'h034, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 'h038,  1, 'h030, 1, 0,  1, 'h034, 1, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 'h038,  0, 'h000, 0, 0,  0, 'h000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 'h040,  0, 'h000, 0, 0,  1, 'h040, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 'h000,  1, 'h040, 0, 1,  0, 'h000, 0, 1));

    drive(1, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].iv, tbl[i].st, tbl[i].fl, tbl[i].clr, tbl[i].p);
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("d2", i, act2(), exp_payload(e.v2, e.p2), sc2, e.s2, bc2, e.b2);
      check("d1", i, act1(), exp_payload(e.v1, e.p1), {14'd0, sc1}, e.s1, {14'd0, bc1}, e.b1);
    end

    // Random stream: ordering through stalls and flushes, every valid output in issue order.
    np     = 32'h1000;
    n_pop2 = 0;
    n_pop1 = 0;
    for (int c = 0; c < 300; c++) begin
      r_iv = 1'($urandom_range(0, 3) != 0);
      r_st = 1'($urandom_range(0, 3) == 0);
      r_fl = 1'($urandom_range(0, 19) == 0);
      drive(0, r_iv, r_st, r_fl, 0, np);
      if (r_fl) begin
        sb2.delete();
        sb1.delete();
      end else if (!r_st && r_iv) begin
        sb2.push_back(np);
        sb1.push_back(np);
      end
      np += 32'd4;
      @(posedge clk);
      #1;
      if (!r_fl && !r_st) begin
        if (ov2) begin
          if (sb2.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb2 #%0d: valid output %h with nothing outstanding", n_pop2, pcc2);
          end else begin
            check_pl("sb2", n_pop2, act2(), exp_payload(1'b1, sb2.pop_front()));
          end
          n_pop2++;
        end
        if (ov1) begin
          if (sb1.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb1 #%0d: valid output %h with nothing outstanding", n_pop1, pcc1);
          end else begin
            check_pl("sb1", n_pop1, act1(), exp_payload(1'b1, sb1.pop_front()));
          end
          n_pop1++;
        end
      end
    end
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, 0, 0, 32'h0);
      @(posedge clk);
      #1;
      if (ov2 && sb2.size() != 0) check_pl("drain2", c, act2(), exp_payload(1'b1, sb2.pop_front()));
      if (ov1 && sb1.size() != 0) check_pl("drain1", c, act1(), exp_payload(1'b1, sb1.pop_front()));
    end
    n_checks++;
    if (sb2.size() != 0 || sb1.size() != 0) begin
      n_errors++;
      $display("FAIL drain_empty: got %0d/%0d outstanding, want 0/0", sb2.size(), sb1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/idex_stage_reg.md
# idex_stage_reg

Parametrised ID→EX pipeline register for the TinyRISC core. It carries PC, instruction, operands A/B/op2, the control word and the branch target from decode to execute, through DEPTH back-to-back register slots. Unlike the fixed single-stage register it replaces, it has:

- a valid bit per slot;
- stall (hold) and flush (squash) inputs;
- bubble insertion with a canonical NOP;
- saturating stall and bubble performance counters for the hazard unit and debug.

## Interface
- XLEN, 32, width of PC, instruction, operand and branch-target fields
- CTRL_W, 22, control-word width
- DEPTH, 1, number of register slots (1..4); latency in cycles
- CNT_W, 16, performance-counter width
- NOP_INSTR, 32'h6800_0000, instruction loaded into bubbles (SimpleRisc nop)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  decode presents a real instruction this cycle
- stall  in  1  hold all slots (hazard unit)
- flush  in  1  squash all slots (taken branch / exception)
- cnt_clr  in  1  clear both counters
- pc, instruction, a, b, op2, branch_target  in  XLEN each  decode payload
- control  in  CTRL_W  decode control word
- out_valid  out  1  last slot holds a real instruction
- pcc, instr, ao, bo, oppo, bto  out  XLEN each  last-slot payload
- co  out  CTRL_W  last-slot control word
- stall_cnt  out  CNT_W  cycles with stall=1 and flush=0
- bubble_cnt  out  CNT_W  bubbles entering slot 0

## Operation
- Clock is clk; reset is synchronous and active-high on rst; no other clocks.
- Per-edge priority: rst > flush > stall > advance.
- **rst:** every slot becomes a bubble; both counters reset to 0.
  - Bubble contents: valid=0, control=0, instruction=NOP_INSTR, all other fields 0.
- **flush:** every slot becomes a bubble, overriding stall and in_valid. bubble_cnt increments by 1; stall_cnt does not.
- **stall (flush=0):** all slots hold their contents; inputs are ignored; stall_cnt increments.
- **advance:** slot[k] ← slot[k-1] for k≥1.
  - Slot 0 loads the inputs with valid=1 if in_valid=1.
  - Slot 0 loads a bubble if in_valid=0, and bubble_cnt increments.
- Bubble fields are forced, never captured, so bubble outputs are deterministic.
- Outputs are driven directly from the last slot; there is no combinational path from the inputs.
- Counters saturate at 2^CNT_W−1 and do not wrap.
  - cnt_clr zeroes both counters on the next edge and wins over a same-cycle increment.
- Simultaneous stall and flush: flush wins and the slots are squashed. A stall asserted across a flush resumes holding bubbles.

## Timing
- Latency: an input accepted at edge n appears on the outputs after edge n+DEPTH−1 (DEPTH=1: visible right after the capturing edge).
- Stall: outputs are unchanged for every cycle stall=1; the edge after stall deasserts advances normally.
- Flush: out_valid=0 and co=0 from the edge that samples flush. The first post-flush instruction reaches the outputs DEPTH edges later.
- Reset mid-stream: one rst edge discards everything. The first edge with rst=0 behaves as advance/stall/flush per inputs.
- Reset values: out_valid=0, co=0, instr=NOP_INSTR, pcc/ao/bo/oppo/bto=0, stall_cnt=0, bubble_cnt=0.

## Structure
- Package tinyrisc_pkg holds:
  - XLEN, CTRL_W defaults and NOP_INSTR;
  - payload struct idex_payload_t {valid, pc, instr, a, b, op2, ctrl, bt};
  - constant IDEX_BUBBLE of that type.
- Sub-module idex_slot: one payload register with load/hold/clear, instantiated DEPTH times via generate. Counters live in the top module.
- Elaboration check: DEPTH in 1..4, CNT_W ≥ 2.

## Test plan
- Reset: rst high 2 cycles, then low with in_valid=0 → out_valid=0, instr=32'h6800_0000, co=0, both counters 0.
- Streaming, DEPTH=1: pc=0x100,0x104,0x108 on consecutive cycles with in_valid=1 → pcc shows each one edge later, out_valid=1, bubble_cnt stays 0.
- Stall, DEPTH=2: stream pc 0x10, 0x14, 0x18; stall 3 cycles while 0x10 is at the output → pcc=0x10 held 3 cycles, then 0x14; stall_cnt=3.
- Flush with stall: flush=1 and stall=1 together with two valid entries in flight (DEPTH=2) → next edge out_valid=0, co=0; the following edge's input appears after 2 edges; bubble_cnt=1.
- Saturation: CNT_W=2, in_valid=0 for 6 cycles → bubble_cnt reaches 3 and holds; cnt_clr with in_valid=0 → 0 on next edge.
- Mid-stream reset: rst during stall with valid data → all outputs at reset values next edge; stall_cnt=0.
